sys_mac_row: RTL and testbench



---
 rtl/sys_pkg.sv | 14 +
 rtl/sys_fifo.sv | 60 ++++++
 rtl/sys_mac_row.sv | 125 ++++++++++++
 tb/tb_sys_mac_row.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared types and constants for the MAC row compute stage.
package sys_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DATA_W  = 16;
  localparam int PROD_W  = 32;
  localparam int S16_MAX = 32767;
  localparam int S16_MIN = -32768;

endpackage

// File: rtl/sys_fifo.sv
// Operand FIFO: push strobe from the producer, pop from the MAC engine,
// head word visible combinationally, almost-full flag for back-pressure.
// A push that coincides with a pop is accepted even when full, since the
// pop frees the slot in the same cycle.
module sys_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             ovf_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign afull     = (cnt_q >= (AW+1)'(AF_LEVEL));
  assign dout      = mem_q[rd_q];
  assign do_pop    = pop && !empty && !clear;
  assign do_push   = push && (!full || do_pop) && !clear;
  assign ovf_pulse = push && full && !do_pop && !clear;

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy count; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sys_mac_row.sv
// MAC row: pops A/B operand pairs, multiplies in stage 1, accumulates in
// stage 2, and every cnt_max products emits a scaled, saturated result.
module sys_mac_row
  import sys_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        max_cntr,
  input  logic              awe,
  input  logic [DATA_W-1:0] a_in,
  input  logic              bwe,
  input  logic [DATA_W-1:0] b_in,
  output logic              aff,
  output logic              bff,
  output logic [DATA_W-1:0] s_out,
  output logic              sat,
  output logic              sw,
  output logic              ovf
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(S16_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(S16_MIN);

  state_e                    state_q;
  logic [7:0]                cnt_max_q, elem_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [PROD_W-1:0]  prod_q;
  logic                      valid1_q;
  logic [DATA_W-1:0]         s_out_q;
  logic                      sat_q, sw_q, ovf_q;

  logic [DATA_W-1:0]         a_head, b_head;
  logic                      a_empty, b_empty, a_full, b_full;
  logic                      a_ovf, b_ovf, pop;
  logic signed [PROD_W-1:0]  prod_d;
  logic signed [ACC_W-1:0]   acc_next, shifted;
  logic [8:0]                elem_inc;
  logic                      last;
  logic [DATA_W-1:0]         s_out_d;
  logic                      sat_d;

  // Start preempts popping so nothing leaves a FIFO that is being cleared.
  assign pop = (state_q == ST_RUN) && !a_empty && !b_empty && !start;

  sys_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .WIDTH(DATA_W)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .clear(start), .push(awe), .din(a_in), .pop(pop),
    .dout(a_head), .empty(a_empty), .full(a_full), .afull(aff), .ovf_pulse(a_ovf)
  );

  sys_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .WIDTH(DATA_W)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .clear(start), .push(bwe), .din(b_in), .pop(pop),
    .dout(b_head), .empty(b_empty), .full(b_full), .afull(bff), .ovf_pulse(b_ovf)
  );

  // Stage-1 product and stage-2 accumulate/scale/clamp arithmetic.
  always_comb begin
    prod_d   = $signed(a_head) * $signed(b_head);
    acc_next = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    shifted  = acc_next >>> FRAC;
    elem_inc = {1'b0, elem_q} + 9'd1;
    last     = (elem_inc == {1'b0, cnt_max_q});
    s_out_d  = shifted[DATA_W-1:0];
    sat_d    = 1'b0;
    if (shifted > SAT_HI) begin
      s_out_d = SAT_HI[DATA_W-1:0];
      sat_d   = 1'b1;
    end else if (shifted < SAT_LO) begin
      s_out_d = SAT_LO[DATA_W-1:0];
      sat_d   = 1'b1;
    end
  end

  // Run control, MAC pipeline and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_max_q <= '0;
      elem_q    <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      valid1_q  <= 1'b0;
      s_out_q   <= '0;
      sat_q     <= 1'b0;
      sw_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (start) begin
      state_q   <= (max_cntr != 8'd0) ? ST_RUN : ST_IDLE;
      cnt_max_q <= max_cntr;
      elem_q    <= '0;
      acc_q     <= '0;
      valid1_q  <= 1'b0;
      sw_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sw_q     <= 1'b0;
      valid1_q <= pop;
      if (pop) prod_q <= prod_d;
      if (a_ovf || b_ovf) ovf_q <= 1'b1;
      if (valid1_q) begin
        if (last) begin
          acc_q   <= '0;
          elem_q  <= '0;
          s_out_q <= s_out_d;
          sat_q   <= sat_d;
          sw_q    <= 1'b1;
        end else begin
          acc_q  <= acc_next;
          elem_q <= elem_inc[7:0];
        end
      end
    end
  end

  assign s_out = s_out_q;
  assign sat   = sat_q;
  assign sw    = sw_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sys_mac_row.sv
// Bench for sys_mac_row: cycle-stepped stimulus with a queue-based
// reference model of the operand FIFOs and the grouped dot products.
module tb_sys_mac_row;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  max_cntr;
  logic        awe, bwe;
  logic [15:0] a_in, b_in;
  logic        aff, bff, sat, sw, ovf;
  logic [15:0] s_out;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  sys_mac_row dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cntr(max_cntr),
    .awe(awe), .a_in(a_in), .bwe(bwe), .b_in(b_in),
    .aff(aff), .bff(bff), .s_out(s_out), .sat(sat), .sw(sw), .ovf(ovf)
  );

  // reference model state
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] exp_q[$];
  bit          exp_sat_q[$];
  int          due_q[$];
  bit          m_run;
  int          m_cnt_max;
  int          m_n;
  longint      m_acc;
  logic [15:0] m_s;
  bit          m_sat;
  bit          m_ovf;
  int          cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    check_val("sw",    {31'b0, sw},    {31'b0, (due_q.size() > 0 && due_q[0] == cyc)});
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      m_s   = exp_q.pop_front();
      m_sat = exp_sat_q.pop_front();
    end
    check_val("s_out", {16'b0, s_out}, {16'b0, m_s});
    check_val("sat",   {31'b0, sat},   {31'b0, m_sat});
    check_val("aff",   {31'b0, aff},   {31'b0, (qa.size() >= 12)});
    check_val("bff",   {31'b0, bff},   {31'b0, (qb.size() >= 12)});
    check_val("ovf",   {31'b0, ovf},   {31'b0, m_ovf});
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete();
    exp_q.delete(); exp_sat_q.delete(); due_q.delete();
    m_acc = 0; m_n = 0; m_ovf = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; max_cntr = 0; awe = 0; bwe = 0; a_in = 0; b_in = 0;
    @(posedge clk); @(posedge clk); #1;
    cyc++;
    model_clear();
    m_run = 0; m_cnt_max = 0; m_s = 0; m_sat = 0;
    check_outputs();
    rst_n = 1'b1;
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input bit st, input int mc, input bit aw, input logic [15:0] a,
                      input bit bw, input logic [15:0] b);
    logic [15:0] pa, pb;
    longint      sh;
    start = st; max_cntr = mc[7:0]; awe = aw; a_in = a; bwe = bw; b_in = b;
    cyc++;
    if (st) begin
      model_clear();
      m_cnt_max = mc;
      m_run     = (mc != 0);
    end else begin
      if (m_run && qa.size() > 0 && qb.size() > 0) begin
        pa = qa.pop_front();
        pb = qb.pop_front();
        m_acc += longint'($signed(pa)) * longint'($signed(pb));
        m_n++;
        if (m_n == m_cnt_max) begin
          sh = m_acc >>> 8;
          if (sh > 32767)       begin exp_q.push_back(16'h7FFF); exp_sat_q.push_back(1); end
          else if (sh < -32768) begin exp_q.push_back(16'h8000); exp_sat_q.push_back(1); end
          else                  begin exp_q.push_back(sh[15:0]); exp_sat_q.push_back(0); end
          due_q.push_back(cyc + 1);
          m_acc = 0;
          m_n   = 0;
        end
      end
      if (aw) begin if (qa.size() < 16) qa.push_back(a); else m_ovf = 1; end
      if (bw) begin if (qb.size() < 16) qb.push_back(b); else m_ovf = 1; end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    cyc = 0;
    do_reset();

    // 4-term dot product with unity B
    step(1, 4, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 16'(i * 256), 1, 16'h0100);
    idle(4);
    check_val("dot4_s_out", {16'b0, s_out}, 32'h0A00);
    check_val("dot4_sat",   {31'b0, sat},   32'h0);

    // positive and negative saturation
    step(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 16'h7FFF, 1, 16'h7FFF);
    idle(4);
    check_val("satpos_s_out", {16'b0, s_out}, 32'h7FFF);
    check_val("satpos_sat",   {31'b0, sat},   32'h1);
    step(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 16'h8000, 1, 16'h7FFF);
    idle(4);
    check_val("satneg_s_out", {16'b0, s_out}, 32'h8000);
    check_val("satneg_sat",   {31'b0, sat},   32'h1);

    // fill A with no B: almost-full, full, overflow
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 16'($urandom), 0, 0);
    check_val("fill_aff", {31'b0, aff}, 32'h1);
    check_val("fill_bff", {31'b0, bff}, 32'h0);
    check_val("fill_ovf", {31'b0, ovf}, 32'h1);

    // push and pop together while A is full: no overflow
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 16'($urandom), 0, 0);
    step(0, 0, 0, 0, 1, 16'h0100);
    step(0, 0, 1, 16'h1234, 0, 0);
    check_val("fullpp_ovf", {31'b0, ovf}, 32'h0);
    check_val("fullpp_aff", {31'b0, aff}, 32'h1);
    idle(3);

    // B lags A by 5 cycles, one result per pair
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++)
      step(0, 0, i < 8, 16'($urandom), (i >= 5), 16'($urandom));
    idle(4);

    // mid-run restart with accumulated pairs and overflowed FIFO
    step(1, 8, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 16'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'($urandom));
    step(0, 0, 0, 0, 0, 0);
    step(1, 2, 1, 16'h5555, 1, 16'h5555);
    check_val("restart_ovf", {31'b0, ovf}, 32'h0);
    check_val("restart_aff", {31'b0, aff}, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'($urandom), 1, 16'($urandom));
    idle(4);

    // max_cntr = 0 stays idle
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 16'($urandom), 1, 16'($urandom));
    idle(3);

    // randomized traffic with occasional restarts and one reset
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if ($urandom_range(0, 39) == 0)
        step(1, $urandom_range(0, 5), $urandom_range(0, 1), 16'($urandom),
             $urandom_range(0, 1), 16'($urandom));
      else
        step(0, $urandom_range(0, 255), ($urandom_range(0, 9) < 6), 16'($urandom),
             ($urandom_range(0, 9) < 6), 16'($urandom));
    end
    idle(40);
    check_val("drain_pending", due_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
